branch_resolution_unit: RTL and testbench

Execute-stage counterpart of the fetch-side branch predictor. Compares each resolved control-flow instruction against the prediction it carried down the pipeline and produces the predictor training signals (`pc_execution`, `branch_addr_result_exec`, `branch_taken_result_exec`, `is_branch_EX`). On a mispredict it raises a one-cycle flush and holds a redirect PC until fetch accepts it. It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/branch_resolution_unit_pkg.sv | 26 ++
 rtl/branch_resolution_unit_if.sv | 38 +++
 rtl/branch_resolution_unit_sat_counter.sv | 21 ++
 rtl/branch_resolution_unit.sv | 116 +++++++++++
 tb/tb_branch_resolution_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
// riscv_pkg comes first because drac_pkg sizes its training bundle from XLEN.

package riscv_pkg;
    localparam int XLEN = 64;
endpackage

package drac_pkg;
    import riscv_pkg::*;

    // Distance from one instruction to the next on the fall-through path.
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } bru_state_t;

    // Training bundle sent back to the fetch-side predictor.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] addr;
        logic            taken;
        logic            valid;
    } bp_update_t;
endpackage

// File: rtl/branch_resolution_unit_if.sv
// EX-stage branch bus: resolved instruction plus carried prediction in,
// predictor training, flush and fetch redirect out.

interface branch_resolution_unit_if;
    logic                       valid_ex_i;
    logic                       is_branch_ex_i;
    logic [riscv_pkg::XLEN-1:0] pc_ex_i;
    logic                       taken_ex_i;
    logic [riscv_pkg::XLEN-1:0] target_ex_i;
    logic                       pred_is_branch_ex_i;
    logic                       pred_taken_ex_i;
    logic [riscv_pkg::XLEN-1:0] pred_addr_ex_i;
    logic                       redirect_ready_i;

    logic [riscv_pkg::XLEN-1:0] pc_execution_o;
    logic [riscv_pkg::XLEN-1:0] branch_addr_result_exec_o;
    logic                       branch_taken_result_exec_o;
    logic                       is_branch_EX_o;
    logic                       flush_o;
    logic                       redirect_valid_o;
    logic [riscv_pkg::XLEN-1:0] redirect_pc_o;

    // Pipeline / fetch side.
    modport master (
        output valid_ex_i, is_branch_ex_i, pc_ex_i, taken_ex_i, target_ex_i,
               pred_is_branch_ex_i, pred_taken_ex_i, pred_addr_ex_i, redirect_ready_i,
        input  pc_execution_o, branch_addr_result_exec_o, branch_taken_result_exec_o,
               is_branch_EX_o, flush_o, redirect_valid_o, redirect_pc_o
    );

    // Branch resolution unit side.
    modport slave (
        input  valid_ex_i, is_branch_ex_i, pc_ex_i, taken_ex_i, target_ex_i,
               pred_is_branch_ex_i, pred_taken_ex_i, pred_addr_ex_i, redirect_ready_i,
        output pc_execution_o, branch_addr_result_exec_o, branch_taken_result_exec_o,
               is_branch_EX_o, flush_o, redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_resolution_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    // Count one per inc_i pulse, holding once the maximum is reached.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolution: checks each resolved instruction against
// its carried prediction, trains the predictor, and redirects fetch on a miss.

module branch_resolution_unit
    import riscv_pkg::*;
    import drac_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    branch_resolution_unit_if.slave bus,
    output logic [CNT_WIDTH-1:0]    branch_count_o,
    output logic [CNT_WIDTH-1:0]    mispredict_count_o
);

    bru_state_t      state_q;
    bp_update_t      train_q;
    logic            flush_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            accept;
    logic            pred_taken;
    logic            miss_raw;
    logic            mispredict;
    logic            train;
    logic [XLEN-1:0] next_pc;

    // Classify the EX instruction against the prediction it carried from fetch.
    always_comb begin
        // NOTE: every output of this block is assigned up front so no latch is inferred.
        accept     = bus.valid_ex_i && (state_q == IDLE);
        pred_taken = bus.pred_is_branch_ex_i & bus.pred_taken_ex_i;
        next_pc    = bus.pc_ex_i + XLEN'(INSTR_BYTES);
        miss_raw   = 1'b0;
        if (bus.is_branch_ex_i) begin
            if (bus.taken_ex_i) begin
                next_pc = bus.target_ex_i;
            end
            if (bus.taken_ex_i != pred_taken) begin
                miss_raw = 1'b1;
            end else if (bus.taken_ex_i && (bus.target_ex_i != bus.pred_addr_ex_i)) begin
                miss_raw = 1'b1;
            end
        end else if (pred_taken) begin
            // A predictor hit on a non-branch sent fetch down a bogus path.
            miss_raw = 1'b1;
        end
        mispredict = accept && miss_raw;
        train      = accept && bus.is_branch_ex_i;
    end

    // Training bundle: data holds between strobes, valid is a one-cycle pulse.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rstn_i) begin
            train_q <= '0;
        end else begin
            train_q.valid <= train;
            if (train) begin
                train_q.pc    <= bus.pc_ex_i;
                train_q.addr  <= bus.target_ex_i;
                train_q.taken <= bus.taken_ex_i;
            end
        end
    end

    // Redirect FSM: flush pulses on entry, redirect PC held until fetch takes it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mispredict) begin
                        state_q       <= REDIRECT;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= next_pc;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (train),
        .count_o (branch_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (mispredict),
        .count_o (mispredict_count_o)
    );

    assign bus.pc_execution_o             = train_q.pc;
    assign bus.branch_addr_result_exec_o  = train_q.addr;
    assign bus.branch_taken_result_exec_o = train_q.taken;
    assign bus.is_branch_EX_o             = train_q.valid;
    assign bus.flush_o                    = flush_q;
    assign bus.redirect_valid_o           = (state_q == REDIRECT);
    assign bus.redirect_pc_o              = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: one task per scenario with
// hand-computed expectations, plus a 4-bit-counter instance for saturation.

module tb_branch_resolution_unit;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic [3:0]  bcnt4;
    logic [3:0]  mcnt4;

    branch_resolution_unit_if bus ();
    branch_resolution_unit_if bus4 ();

    branch_resolution_unit #(.CNT_WIDTH(32)) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .bus                (bus),
        .branch_count_o     (bcnt),
        .mispredict_count_o (mcnt)
    );

    branch_resolution_unit #(.CNT_WIDTH(4)) dut4 (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .bus                (bus4),
        .branch_count_o     (bcnt4),
        .mispredict_count_o (mcnt4)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic [63:0] pc, input logic tk,
                         input logic [63:0] tgt, input logic pb, input logic ptk,
                         input logic [63:0] pa, input logic rdy);
        bus.valid_ex_i          = v;
        bus.is_branch_ex_i      = br;
        bus.pc_ex_i             = pc;
        bus.taken_ex_i          = tk;
        bus.target_ex_i         = tgt;
        bus.pred_is_branch_ex_i = pb;
        bus.pred_taken_ex_i     = ptk;
        bus.pred_addr_ex_i      = pa;
        bus.redirect_ready_i    = rdy;
    endtask

    task automatic drive4(input logic v, input logic rdy);
        bus4.valid_ex_i          = v;
        bus4.is_branch_ex_i      = 1'b1;
        bus4.pc_ex_i             = 64'h8000;
        bus4.taken_ex_i          = 1'b0;
        bus4.target_ex_i         = 64'h8100;
        bus4.pred_is_branch_ex_i = 1'b1;
        bus4.pred_taken_ex_i     = 1'b1;
        bus4.pred_addr_ex_i      = 64'h8100;
        bus4.redirect_ready_i    = rdy;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        drive4(1'b0, 1'b0);
        step();
        step();
        total++; if (bus.pc_execution_o !== 64'h0) begin bad++; $display("FAIL reset_pc_exec: got=%h want=0", bus.pc_execution_o); end
        total++; if (bus.branch_addr_result_exec_o !== 64'h0) begin bad++; $display("FAIL reset_train_addr: got=%h want=0", bus.branch_addr_result_exec_o); end
        total++; if (bus.branch_taken_result_exec_o !== 1'b0) begin bad++; $display("FAIL reset_train_taken: got=%b want=0", bus.branch_taken_result_exec_o); end
        total++; if (bus.is_branch_EX_o !== 1'b0) begin bad++; $display("FAIL reset_is_branch: got=%b want=0", bus.is_branch_EX_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush: got=%b want=0", bus.flush_o); end
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL reset_redir_valid: got=%b want=0", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 64'h0) begin bad++; $display("FAIL reset_redir_pc: got=%h want=0", bus.redirect_pc_o); end
        total++; if (bcnt !== 32'd0) begin bad++; $display("FAIL reset_bcnt: got=%0d want=0", bcnt); end
        total++; if (mcnt !== 32'd0) begin bad++; $display("FAIL reset_mcnt: got=%0d want=0", mcnt); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_correct();
        drive(1'b1, 1'b1, 64'h1000, 1'b1, 64'h1040, 1'b1, 1'b1, 64'h1040, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.is_branch_EX_o !== 1'b1) begin bad++; $display("FAIL ok_is_branch: got=%b want=1", bus.is_branch_EX_o); end
        total++; if (bus.pc_execution_o !== 64'h1000) begin bad++; $display("FAIL ok_pc_exec: got=%h want=1000", bus.pc_execution_o); end
        total++; if (bus.branch_addr_result_exec_o !== 64'h1040) begin bad++; $display("FAIL ok_train_addr: got=%h want=1040", bus.branch_addr_result_exec_o); end
        total++; if (bus.branch_taken_result_exec_o !== 1'b1) begin bad++; $display("FAIL ok_train_taken: got=%b want=1", bus.branch_taken_result_exec_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL ok_flush: got=%b want=0", bus.flush_o); end
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL ok_redir_valid: got=%b want=0", bus.redirect_valid_o); end
        total++; if (bcnt !== 32'd1) begin bad++; $display("FAIL ok_bcnt: got=%0d want=1", bcnt); end
        total++; if (mcnt !== 32'd0) begin bad++; $display("FAIL ok_mcnt: got=%0d want=0", mcnt); end
        step();
        total++; if (bus.is_branch_EX_o !== 1'b0) begin bad++; $display("FAIL ok_strobe_pulse: got=%b want=0", bus.is_branch_EX_o); end
        total++; if (bus.pc_execution_o !== 64'h1000) begin bad++; $display("FAIL ok_pc_hold: got=%h want=1000", bus.pc_execution_o); end
    endtask

    task automatic test_dir_mispredict();
        drive(1'b1, 1'b1, 64'h2000, 1'b0, 64'h2400, 1'b1, 1'b1, 64'h2400, 1'b0);
        step();
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL dir_flush: got=%b want=1", bus.flush_o); end
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL dir_redir_valid: got=%b want=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 64'h2004) begin bad++; $display("FAIL dir_redir_pc: got=%h want=2004", bus.redirect_pc_o); end
        total++; if (bus.is_branch_EX_o !== 1'b1) begin bad++; $display("FAIL dir_trains: got=%b want=1", bus.is_branch_EX_o); end
        total++; if (bus.branch_taken_result_exec_o !== 1'b0) begin bad++; $display("FAIL dir_train_taken: got=%b want=0", bus.branch_taken_result_exec_o); end
        total++; if (bcnt !== 32'd2) begin bad++; $display("FAIL dir_bcnt: got=%0d want=2", bcnt); end
        total++; if (mcnt !== 32'd1) begin bad++; $display("FAIL dir_mcnt: got=%0d want=1", mcnt); end
        // Wrong-path instruction that would both train and mispredict if accepted.
        drive(1'b1, 1'b1, 64'h5000, 1'b1, 64'h5040, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL dir_hold_valid[%0d]: got=%b want=1", k, bus.redirect_valid_o); end
            total++; if (bus.redirect_pc_o !== 64'h2004) begin bad++; $display("FAIL dir_hold_pc[%0d]: got=%h want=2004", k, bus.redirect_pc_o); end
            total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL dir_flush_pulse[%0d]: got=%b want=0", k, bus.flush_o); end
            total++; if (bus.is_branch_EX_o !== 1'b0) begin bad++; $display("FAIL dir_wrongpath_train[%0d]: got=%b want=0", k, bus.is_branch_EX_o); end
        end
        bus.redirect_ready_i = 1'b1;
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL dir_after_hs_valid: got=%b want=0", bus.redirect_valid_o); end
        total++; if (bus.pc_execution_o !== 64'h2000) begin bad++; $display("FAIL dir_wrongpath_pc: got=%h want=2000", bus.pc_execution_o); end
        total++; if (bcnt !== 32'd2) begin bad++; $display("FAIL dir_wrongpath_bcnt: got=%0d want=2", bcnt); end
        total++; if (mcnt !== 32'd1) begin bad++; $display("FAIL dir_wrongpath_mcnt: got=%0d want=1", mcnt); end
    endtask

    task automatic test_target_mispredict();
        // Issued on the first cycle after the handshake; ready high from the start.
        drive(1'b1, 1'b1, 64'h3000, 1'b1, 64'h3100, 1'b1, 1'b1, 64'h3080, 1'b1);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL tgt_flush: got=%b want=1", bus.flush_o); end
        total++; if (bus.redirect_pc_o !== 64'h3100) begin bad++; $display("FAIL tgt_redir_pc: got=%h want=3100", bus.redirect_pc_o); end
        total++; if (bus.branch_addr_result_exec_o !== 64'h3100) begin bad++; $display("FAIL tgt_train_addr: got=%h want=3100", bus.branch_addr_result_exec_o); end
        total++; if (bus.pc_execution_o !== 64'h3000) begin bad++; $display("FAIL tgt_pc_exec: got=%h want=3000", bus.pc_execution_o); end
        total++; if (bcnt !== 32'd3) begin bad++; $display("FAIL tgt_bcnt: got=%0d want=3", bcnt); end
        total++; if (mcnt !== 32'd2) begin bad++; $display("FAIL tgt_mcnt: got=%0d want=2", mcnt); end
        step();
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL tgt_one_cycle_redir: got=%b want=0", bus.redirect_valid_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL tgt_flush_pulse: got=%b want=0", bus.flush_o); end
    endtask

    task automatic test_false_positive();
        drive(1'b1, 1'b0, 64'h4000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h4100, 1'b1);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL fp_flush: got=%b want=1", bus.flush_o); end
        total++; if (bus.redirect_pc_o !== 64'h4004) begin bad++; $display("FAIL fp_redir_pc: got=%h want=4004", bus.redirect_pc_o); end
        total++; if (bus.is_branch_EX_o !== 1'b0) begin bad++; $display("FAIL fp_no_train: got=%b want=0", bus.is_branch_EX_o); end
        total++; if (bus.pc_execution_o !== 64'h3000) begin bad++; $display("FAIL fp_pc_hold: got=%h want=3000", bus.pc_execution_o); end
        total++; if (bcnt !== 32'd3) begin bad++; $display("FAIL fp_bcnt: got=%0d want=3", bcnt); end
        total++; if (mcnt !== 32'd3) begin bad++; $display("FAIL fp_mcnt: got=%0d want=3", mcnt); end
        step();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h8000, 1'b1, 1'b1, 64'h8000, 1'b1);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_redir_valid: got=%b want=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 64'h0) begin bad++; $display("FAIL wrap_redir_pc: got=%h want=0", bus.redirect_pc_o); end
        total++; if (bcnt !== 32'd4) begin bad++; $display("FAIL wrap_bcnt: got=%0d want=4", bcnt); end
        total++; if (mcnt !== 32'd4) begin bad++; $display("FAIL wrap_mcnt: got=%0d want=4", mcnt); end
        step();
    endtask

    task automatic test_reset_mid_redirect();
        drive(1'b1, 1'b1, 64'h6000, 1'b1, 64'h6100, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.redirect_pc_o !== 64'h6100) begin bad++; $display("FAIL rst_pre_redir_pc: got=%h want=6100", bus.redirect_pc_o); end
        rstn = 1'b0;
        step();
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got=%b want=0", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 64'h0) begin bad++; $display("FAIL rst_mid_pc: got=%h want=0", bus.redirect_pc_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL rst_mid_flush: got=%b want=0", bus.flush_o); end
        total++; if (bus.pc_execution_o !== 64'h0) begin bad++; $display("FAIL rst_mid_pc_exec: got=%h want=0", bus.pc_execution_o); end
        total++; if (bcnt !== 32'd0) begin bad++; $display("FAIL rst_mid_bcnt: got=%0d want=0", bcnt); end
        total++; if (mcnt !== 32'd0) begin bad++; $display("FAIL rst_mid_mcnt: got=%0d want=0", mcnt); end
        rstn = 1'b1;
        drive(1'b1, 1'b1, 64'h7000, 1'b1, 64'h7080, 1'b1, 1'b1, 64'h7080, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.is_branch_EX_o !== 1'b1) begin bad++; $display("FAIL rst_after_train: got=%b want=1", bus.is_branch_EX_o); end
        total++; if (bus.pc_execution_o !== 64'h7000) begin bad++; $display("FAIL rst_after_pc_exec: got=%h want=7000", bus.pc_execution_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL rst_after_flush: got=%b want=0", bus.flush_o); end
        total++; if (bcnt !== 32'd1) begin bad++; $display("FAIL rst_after_bcnt: got=%0d want=1", bcnt); end
        step();
    endtask

    task automatic test_saturation();
        // Every accepted instruction mispredicts, so both 4-bit counters track i until 15.
        for (int i = 1; i <= 20; i++) begin
            drive4(1'b1, 1'b1);
            step();
            drive4(1'b0, 1'b1);
            total++; if (bcnt4 !== 4'((i < 15) ? i : 15)) begin bad++; $display("FAIL sat_bcnt[%0d]: got=%0d want=%0d", i, bcnt4, (i < 15) ? i : 15); end
            total++; if (mcnt4 !== 4'((i < 15) ? i : 15)) begin bad++; $display("FAIL sat_mcnt[%0d]: got=%0d want=%0d", i, mcnt4, (i < 15) ? i : 15); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_dir_mispredict();
        test_target_mispredict();
        test_false_positive();
        test_wrap();
        test_reset_mid_redirect();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
